pe_stream_bg: RTL and testbench

//  Parametrised, streaming successor of the background-removal processing element.

---
 rtl/pe_stream_bg_if.sv | 52 +++++
 rtl/pe_stream_bg.sv | 170 +++++++++++++++++
 tb/tb_pe_stream_bg.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/pe_stream_bg_if.sv
// Stream and control bundle for the background-removal processing element.
// The slave side is the processing element; the master side is the frame controller / pixel source and sink.
interface pe_stream_bg_if #(
    parameter int PIX_W = 8
);
    logic             Start_Sum;
    logic             Start_BgRemoval;
    logic             Ack;
    logic             Mode;
    logic [PIX_W+1:0] Threshold;
    logic [PIX_W-1:0] Desired_r;
    logic [PIX_W-1:0] Desired_g;
    logic [PIX_W-1:0] Desired_b;

    logic             In_valid;
    logic             In_ready;
    logic [PIX_W-1:0] In_r;
    logic [PIX_W-1:0] In_g;
    logic [PIX_W-1:0] In_b;

    logic             Out_valid;
    logic             Out_ready;
    logic [PIX_W-1:0] Out_r;
    logic [PIX_W-1:0] Out_g;
    logic [PIX_W-1:0] Out_b;
    logic             Out_is_bg;

    logic [PIX_W-1:0] Bg_r;
    logic [PIX_W-1:0] Bg_g;
    logic [PIX_W-1:0] Bg_b;
    logic             Bg_valid;

    logic             Qi;
    logic             Qs;
    logic             Qsd;
    logic             Qbg;
    logic             Qbgd;

    modport slave (
        input  Start_Sum, Start_BgRemoval, Ack, Mode, Threshold, Desired_r, Desired_g, Desired_b,
        input  In_valid, In_r, In_g, In_b, Out_ready,
        output In_ready, Out_valid, Out_r, Out_g, Out_b, Out_is_bg,
        output Bg_r, Bg_g, Bg_b, Bg_valid, Qi, Qs, Qsd, Qbg, Qbgd
    );

    modport master (
        output Start_Sum, Start_BgRemoval, Ack, Mode, Threshold, Desired_r, Desired_g, Desired_b,
        output In_valid, In_r, In_g, In_b, Out_ready,
        input  In_ready, Out_valid, Out_r, Out_g, Out_b, Out_is_bg,
        input  Bg_r, Bg_g, Bg_b, Bg_valid, Qi, Qs, Qsd, Qbg, Qbgd
    );
endinterface

// File: rtl/pe_stream_bg.sv
// Streaming background-removal PE: a SUM pass averages NUM_PIX pixels into a background colour,
// a BGR pass classifies each streamed pixel by L1 distance to it and replaces or masks background pixels.
module pe_stream_bg #(
    parameter int PIX_W   = 8,
    parameter int LOG2_N  = 4,
    parameter int REG_OUT = 1
) (
    input  logic          Clk,
    input  logic          Reset_n,
    pe_stream_bg_if.slave bus
);
    localparam int NUM_PIX = 1 << LOG2_N;
    localparam int SUM_W   = PIX_W + LOG2_N;
    localparam int CNT_W   = LOG2_N + 1;

    if (REG_OUT != 1) begin : g_reg_out_check
        $error("pe_stream_bg: only REG_OUT=1 is implemented");
    end

    typedef enum logic [2:0] {S_INI, S_SUM, S_DONE_S, S_BGR, S_DONE_B} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_in_q, cnt_out_q;
    logic [SUM_W-1:0]   sum_r_q, sum_g_q, sum_b_q;
    logic [PIX_W-1:0]   bg_r_q, bg_g_q, bg_b_q;
    logic               bg_valid_q;
    logic               vld_p1;
    logic [PIX_W-1:0]   out_r_p1, out_g_p1, out_b_p1;
    logic               out_bg_p1;
    logic               in_ready, fire_in, fire_out, last_in, last_out;
    logic               is_bg_p0;
    logic [PIX_W+1:0]   dist_p0;

    function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W-1:0] a, input logic [PIX_W-1:0] b);
        logic signed [PIX_W:0] d;
        logic        [PIX_W:0] m;
        d = signed'({1'b0, a}) - signed'({1'b0, b});
        m = (d < 0) ? -d : d;
        return m[PIX_W-1:0];
    endfunction

    function automatic logic [PIX_W+1:0] l1_dist(input logic [PIX_W-1:0] r, g, b, br, bgc, bb);
        return {2'b00, abs_diff(r, br)} + {2'b00, abs_diff(g, bgc)} + {2'b00, abs_diff(b, bb)};
    endfunction

    // Truncating average: NUM_PIX is a power of two, so the mean is the top PIX_W bits of the sum.
    function automatic logic [PIX_W-1:0] avg(input logic [SUM_W-1:0] s);
        return s[SUM_W-1:LOG2_N];
    endfunction

    assign last_in  = (cnt_in_q == CNT_W'(NUM_PIX - 1));
    assign last_out = (cnt_out_q == CNT_W'(NUM_PIX - 1));
    assign fire_in  = bus.In_valid && in_ready;
    assign fire_out = vld_p1 && bus.Out_ready;

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= S_INI;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            S_INI: begin
                if (bus.Start_Sum)                        state_d = S_SUM;
                else if (bus.Start_BgRemoval && bg_valid_q) state_d = S_BGR;
            end
            S_SUM: begin
                in_ready = 1'b1;
                if (bus.In_valid && last_in) state_d = S_DONE_S;
            end
            S_DONE_S: if (bus.Ack) state_d = S_INI;
            S_BGR: begin
                // A stalled output blocks intake so the held pixel is never overwritten.
                in_ready = (cnt_in_q < CNT_W'(NUM_PIX)) && (!vld_p1 || bus.Out_ready);
                if (fire_out && last_out) state_d = S_DONE_B;
            end
            S_DONE_B: if (bus.Ack) state_d = S_INI;
            default:  state_d = S_INI;
        endcase
    end

    // Stage p0: classification of the pixel being accepted
    assign dist_p0  = l1_dist(bus.In_r, bus.In_g, bus.In_b, bg_r_q, bg_g_q, bg_b_q);
    assign is_bg_p0 = (dist_p0 <= bus.Threshold);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            cnt_in_q   <= '0;
            cnt_out_q  <= '0;
            sum_r_q    <= '0;
            sum_g_q    <= '0;
            sum_b_q    <= '0;
            bg_r_q     <= '0;
            bg_g_q     <= '0;
            bg_b_q     <= '0;
            bg_valid_q <= 1'b0;
            vld_p1     <= 1'b0;
            out_r_p1   <= '0;
            out_g_p1   <= '0;
            out_b_p1   <= '0;
            out_bg_p1  <= 1'b0;
        end else begin
            case (state_q)
                S_INI: begin
                    cnt_in_q  <= '0;
                    cnt_out_q <= '0;
                    if (bus.Start_Sum) begin
                        sum_r_q <= '0;
                        sum_g_q <= '0;
                        sum_b_q <= '0;
                    end
                end
                S_SUM: if (fire_in) begin
                    if (last_in) begin
                        bg_r_q     <= avg(sum_r_q + SUM_W'(bus.In_r));
                        bg_g_q     <= avg(sum_g_q + SUM_W'(bus.In_g));
                        bg_b_q     <= avg(sum_b_q + SUM_W'(bus.In_b));
                        bg_valid_q <= 1'b1;
                        cnt_in_q   <= '0;
                    end else begin
                        sum_r_q  <= sum_r_q + SUM_W'(bus.In_r);
                        sum_g_q  <= sum_g_q + SUM_W'(bus.In_g);
                        sum_b_q  <= sum_b_q + SUM_W'(bus.In_b);
                        cnt_in_q <= cnt_in_q + CNT_W'(1);
                    end
                end
                S_BGR: begin
                    // Stage p1: registered output pixel
                    if (fire_in) begin
                        vld_p1    <= 1'b1;
                        out_bg_p1 <= is_bg_p0;
                        out_r_p1  <= is_bg_p0 ? (bus.Mode ? '0 : bus.Desired_r) : bus.In_r;
                        out_g_p1  <= is_bg_p0 ? (bus.Mode ? '0 : bus.Desired_g) : bus.In_g;
                        out_b_p1  <= is_bg_p0 ? (bus.Mode ? '0 : bus.Desired_b) : bus.In_b;
                        cnt_in_q  <= cnt_in_q + CNT_W'(1);
                    end else if (fire_out) begin
                        vld_p1 <= 1'b0;
                    end
                    if (fire_out) begin
                        if (last_out) begin
                            cnt_out_q <= '0;
                            cnt_in_q  <= '0;
                        end else begin
                            cnt_out_q <= cnt_out_q + CNT_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.In_ready  = in_ready;
    assign bus.Out_valid = vld_p1;
    assign bus.Out_r     = out_r_p1;
    assign bus.Out_g     = out_g_p1;
    assign bus.Out_b     = out_b_p1;
    assign bus.Out_is_bg = out_bg_p1;
    assign bus.Bg_r      = bg_r_q;
    assign bus.Bg_g      = bg_g_q;
    assign bus.Bg_b      = bg_b_q;
    assign bus.Bg_valid  = bg_valid_q;
    assign bus.Qi        = (state_q == S_INI);
    assign bus.Qs        = (state_q == S_SUM);
    assign bus.Qsd       = (state_q == S_DONE_S);
    assign bus.Qbg       = (state_q == S_BGR);
    assign bus.Qbgd      = (state_q == S_DONE_B);
endmodule

// File: tb/tb_pe_stream_bg.sv
// Directed bench for pe_stream_bg: inputs change on the falling edge, outputs are checked away from the rising edge.
module tb_pe_stream_bg;
    localparam int PIX_W  = 8;
    localparam int LOG2_N = 4;

    logic Clk = 1'b0;
    logic Reset_n = 1'b0;
    always #5 Clk = ~Clk;

    pe_stream_bg_if #(.PIX_W(PIX_W)) bus ();

    pe_stream_bg #(.PIX_W(PIX_W), .LOG2_N(LOG2_N), .REG_OUT(1)) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .bus    (bus)
    );

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Sends one BGR pixel (called on a falling edge) and checks the registered result one cycle later.
    task automatic px(input string tag, input int r, g, b, er, eg, eb, ebg);
        bus.In_valid = 1'b1;
        bus.In_r = 8'(r); bus.In_g = 8'(g); bus.In_b = 8'(b);
        #1 chk({tag, "_rdy"}, bus.In_ready, 1);
        @(negedge Clk);
        bus.In_valid = 1'b0;
        chk({tag, "_vld"}, bus.Out_valid, 1);
        chk({tag, "_r"}, bus.Out_r, er);
        chk({tag, "_g"}, bus.Out_g, eg);
        chk({tag, "_b"}, bus.Out_b, eb);
        chk({tag, "_isbg"}, bus.Out_is_bg, ebg);
    endtask

    task automatic sum_flat(input int v);
        for (int i = 0; i < 16; i++) begin
            bus.In_valid = 1'b1;
            bus.In_r = 8'(v); bus.In_g = 8'(v); bus.In_b = 8'(v);
            @(negedge Clk);
        end
        bus.In_valid = 1'b0;
    endtask

    task automatic ack();
        bus.Ack = 1'b1;
        @(negedge Clk);
        bus.Ack = 1'b0;
        chk("ack_to_ini", bus.Qi, 1);
    endtask

    task automatic start_bgr();
        bus.Start_BgRemoval = 1'b1;
        @(negedge Clk);
        bus.Start_BgRemoval = 1'b0;
        chk("bgr_entered", bus.Qbg, 1);
    endtask

    initial begin
        int sent, recv, cyc;
        logic stall;
        logic [7:0] held_r;

        bus.Start_Sum = 0; bus.Start_BgRemoval = 0; bus.Ack = 0; bus.Mode = 0;
        bus.Threshold = '0; bus.Desired_r = 0; bus.Desired_g = 0; bus.Desired_b = 0;
        bus.In_valid = 0; bus.In_r = 0; bus.In_g = 0; bus.In_b = 0; bus.Out_ready = 0;

        repeat (2) @(negedge Clk);
        chk("rst_qi", bus.Qi, 1);
        chk("rst_qs", bus.Qs, 0);
        chk("rst_in_ready", bus.In_ready, 0);
        chk("rst_out_valid", bus.Out_valid, 0);
        chk("rst_bg_valid", bus.Bg_valid, 0);
        chk("rst_bg_r", bus.Bg_r, 0);
        chk("rst_out_r", bus.Out_r, 0);
        Reset_n = 1'b1;

        // Start_BgRemoval without an estimate is ignored
        bus.Start_BgRemoval = 1'b1;
        @(negedge Clk);
        bus.Start_BgRemoval = 1'b0;
        chk("t5_bgr_no_est_qi", bus.Qi, 1);
        chk("t5_bgr_no_est_qbg", bus.Qbg, 0);

        // SUM of (100,150,200)+i
        bus.Start_Sum = 1'b1;
        @(negedge Clk);
        bus.Start_Sum = 1'b0;
        chk("t2_qs", bus.Qs, 1);
        chk("t2_in_ready", bus.In_ready, 1);
        for (int i = 0; i < 16; i++) begin
            bus.In_valid = 1'b1;
            bus.In_r = 8'(100 + i); bus.In_g = 8'(150 + i); bus.In_b = 8'(200 + i);
            @(negedge Clk);
        end
        bus.In_valid = 1'b0;
        chk("t2_qsd", bus.Qsd, 1);
        chk("t2_bg_valid", bus.Bg_valid, 1);
        chk("t2_bg_r", bus.Bg_r, 107);
        chk("t2_bg_g", bus.Bg_g, 157);
        chk("t2_bg_b", bus.Bg_b, 207);
        chk("t2_done_not_ready", bus.In_ready, 0);
        bus.Start_Sum = 1'b1;
        @(negedge Clk);
        bus.Start_Sum = 1'b0;
        chk("t2_start_ignored_in_done", bus.Qsd, 1);
        ack();

        // Both starts: SUM wins; estimate becomes (100,100,100)
        bus.Start_Sum = 1'b1; bus.Start_BgRemoval = 1'b1;
        @(negedge Clk);
        bus.Start_Sum = 1'b0; bus.Start_BgRemoval = 1'b0;
        chk("t5_both_qs", bus.Qs, 1);
        chk("t5_both_qbg", bus.Qbg, 0);
        sum_flat(100);
        chk("t3_bg_r", bus.Bg_r, 100);
        chk("t3_bg_b", bus.Bg_b, 100);
        ack();

        // Classification
        bus.Threshold = 10'd10; bus.Desired_r = 0; bus.Desired_g = 255; bus.Desired_b = 0;
        bus.Mode = 1'b0; bus.Out_ready = 1'b1;
        start_bgr();
        px("t3_d10", 105, 103, 102, 0, 255, 0, 1);
        px("t3_d11", 105, 103, 103, 105, 103, 103, 0);
        bus.Mode = 1'b1;
        px("t3_mode1", 100, 100, 100, 0, 0, 0, 1);
        bus.Mode = 1'b0; bus.Threshold = 10'd0;
        px("t3_thr0_eq", 100, 100, 100, 0, 255, 0, 1);
        px("t3_thr0_ne", 101, 100, 100, 101, 100, 100, 0);
        bus.Threshold = 10'd765;
        px("t3_thr_max", 255, 0, 255, 0, 255, 0, 1);
        bus.Threshold = 10'd10;
        for (int i = 0; i < 10; i++) px("t3_fill", 10, 20, 30, 10, 20, 30, 0);
        @(negedge Clk);
        chk("t3_qbgd", bus.Qbgd, 1);
        chk("t3_out_valid_done", bus.Out_valid, 0);
        ack();

        // Random backpressure
        bus.Threshold = 10'd0;
        start_bgr();
        sent = 0; recv = 0; cyc = 0; stall = 1'b0; held_r = '0;
        while (recv < 16 && cyc < 400) begin
            bus.Out_ready = 1'($urandom_range(0, 1));
            bus.In_valid = (sent < 16);
            bus.In_r = 8'(10 + sent); bus.In_g = 8'(20 + sent); bus.In_b = 8'(30 + sent);
            #1;
            if (stall) begin
                chk("t4_hold_vld", bus.Out_valid, 1);
                chk("t4_hold_r", bus.Out_r, held_r);
            end
            if (bus.Out_valid && !bus.Out_ready) chk("t4_stall_blocks_in", bus.In_ready, 0);
            if (bus.Out_valid && bus.Out_ready) begin
                chk("t4_data_r", bus.Out_r, 10 + recv);
                chk("t4_data_b", bus.Out_b, 30 + recv);
                recv++;
            end
            stall = bus.Out_valid && !bus.Out_ready;
            held_r = bus.Out_r;
            if (bus.In_valid && bus.In_ready) sent++;
            @(negedge Clk);
            cyc++;
        end
        bus.In_valid = 1'b0; bus.Out_ready = 1'b1;
        #1;
        chk("t4_handshakes", recv, 16);
        chk("t4_accepted", sent, 16);
        chk("t4_qbgd", bus.Qbgd, 1);
        chk("t4_no_extra_out", bus.Out_valid, 0);
        @(negedge Clk);
        ack();

        // Full throughput
        start_bgr();
        for (int i = 0; i <= 16; i++) begin
            if (i > 0) begin
                chk("t6_vld", bus.Out_valid, 1);
                chk("t6_r", bus.Out_r, 40 + i - 1);
                chk("t6_g", bus.Out_g, 50 + i - 1);
            end
            if (i < 16) begin
                bus.In_valid = 1'b1;
                bus.In_r = 8'(40 + i); bus.In_g = 8'(50 + i); bus.In_b = 8'(60 + i);
                #1 chk("t6_rdy", bus.In_ready, 1);
            end else begin
                bus.In_valid = 1'b0;
            end
            @(negedge Clk);
        end
        chk("t6_qbgd", bus.Qbgd, 1);
        chk("t6_out_valid_done", bus.Out_valid, 0);
        ack();

        // Asynchronous reset mid-BGR with a pending output
        start_bgr();
        bus.Out_ready = 1'b0;
        bus.In_valid = 1'b1;
        bus.In_r = 8'd10; bus.In_g = 8'd20; bus.In_b = 8'd30;
        @(negedge Clk);
        bus.In_valid = 1'b0;
        chk("t1_pending", bus.Out_valid, 1);
        #2 Reset_n = 1'b0;
        #1;
        chk("t1_qi", bus.Qi, 1);
        chk("t1_qbg", bus.Qbg, 0);
        chk("t1_out_valid", bus.Out_valid, 0);
        chk("t1_bg_valid", bus.Bg_valid, 0);
        chk("t1_bg_r", bus.Bg_r, 0);
        @(negedge Clk);
        Reset_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
